seq_div: RTL and testbench

Iterative restoring divider that inverts the combinational multiply path. It accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per clock. It returns quotient and remainder over a second valid/ready handshake. It sits beside the datapath's arithmetic helpers and serves callers that cannot afford a combinational divider.

---
 rtl/seq_div_pkg.sv | 21 ++
 rtl/seq_div_step.sv | 20 ++
 rtl/seq_div.sv | 136 +++++++++++++
 tb/tb_seq_div.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state encoding
// and the constant function that sizes the iteration counter.
package seq_div_pkg;

   typedef enum logic [1:0] {
      SEQ_DIV_IDLE = 2'd0,
      SEQ_DIV_BUSY = 2'd1,
      SEQ_DIV_DONE = 2'd2
   } state_t;

   // ceil(log2(w+1)): enough bits for a counter that must hold the value w
   function automatic int cnt_width(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < (w + 1)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference if it did not go negative.
module seq_div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] divisor,
   input  logic             dividend_bit,
   output logic [WIDTH:0]   rem_out,
   output logic             quotient_bit
);

   logic [WIDTH:0] shifted;

   // A set top bit means the shifted value exceeds any WIDTH-bit divisor.
   assign shifted      = {rem_in[WIDTH-1:0], dividend_bit};
   assign quotient_bit = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
   assign rem_out      = quotient_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (magnitude core plus sign fix-up).
module seq_div
   import seq_div_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] dvd_sh;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH-1:0] q_raw;
   logic [WIDTH-1:0] r_raw;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic             q_bit;
   logic             accept;
   logic             drain;
   logic             last_step;
`ifdef SEQ_DIV_SIGNED_EN
   logic             neg_q;
   logic             neg_r;
`endif

   assign in_ready  = (state == SEQ_DIV_IDLE);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign last_step = (state == SEQ_DIV_BUSY) && (cnt == CNT_W'(WIDTH - 1));

   // The dividend register doubles as the quotient shift register.
   assign q_raw = {dvd_sh[WIDTH-2:0], q_bit};
   assign r_raw = rem_nxt[WIDTH-1:0];

   seq_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem_in      (rem),
      .divisor     (dvs),
      .dividend_bit(dvd_sh[WIDTH-1]),
      .rem_out     (rem_nxt),
      .quotient_bit(q_bit)
   );

   always_comb begin
      dvd_mag = dividend;
      dvs_mag = divisor;
      q_fin   = q_raw;
      r_fin   = r_raw;
`ifdef SEQ_DIV_SIGNED_EN
      if (dividend[WIDTH-1]) dvd_mag = -dividend;
      if (divisor[WIDTH-1])  dvs_mag = -divisor;
      if (neg_q)             q_fin   = -q_raw;
      if (neg_r)             r_fin   = -r_raw;
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SEQ_DIV_IDLE: if (accept) state_nxt = (divisor == '0) ? SEQ_DIV_DONE : SEQ_DIV_BUSY;
         SEQ_DIV_BUSY: if (last_step) state_nxt = SEQ_DIV_DONE;
         SEQ_DIV_DONE: if (drain) state_nxt = SEQ_DIV_IDLE;
         default:      state_nxt = SEQ_DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SEQ_DIV_IDLE;
      else        state <= state_nxt;
   end

   // Results load only on DONE entry; out_valid follows one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         rem         <= '0;
         dvd_sh      <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
         out_valid   <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
`endif
      end else begin
         out_valid <= (state == SEQ_DIV_DONE) && !drain;
         if (accept) begin
            cnt    <= '0;
            rem    <= '0;
            dvd_sh <= dvd_mag;
            dvs    <= dvs_mag;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r  <= dividend[WIDTH-1];
`endif
            if (divisor == '0) begin
               quotient    <= '1;
               remainder   <= dividend;
               div_by_zero <= 1'b1;
            end
         end else if (state == SEQ_DIV_BUSY) begin
            rem    <= rem_nxt;
            dvd_sh <= q_raw;
            cnt    <= cnt + CNT_W'(1);
            if (last_step) begin
               quotient    <= q_fin;
               remainder   <= r_fin;
               div_by_zero <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (WIDTH=16): arithmetic reference model with a
// per-cycle compare process, literal cases, back-pressure, mid-op reset and random ops.
module tb_seq_div;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           lat;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   logic [W:0]   st_rem_in = '0;
   logic [W-1:0] st_div = '0;
   logic         st_bit = 1'b0;
   logic [W:0]   st_rem_out;
   logic         st_q;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   seen_head = 0;
   bit   rand_ready = 0;
   exp_t exp_q[$];
   exp_t e_push;

   always #5 clk = ~clk;

   seq_div #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   seq_div_step #(.WIDTH(W)) u_step_ref (
      .rem_in      (st_rem_in),
      .divisor     (st_div),
      .dividend_bit(st_bit),
      .rem_out     (st_rem_out),
      .quotient_bit(st_q)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   sa;
      int   sb;
`ifdef SEQ_DIV_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      e.acc = 0;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a;
         e.z   = 1'b1;
         e.lat = 1;
      end else begin
         e.q   = W'(sa / sb);
         e.r   = W'(sa % sb);
         e.z   = 1'b0;
         e.lat = W + 1;
      end
      return e;
   endfunction

   // Scoreboard bookkeeping on the active edge: push on accept, pop on drain.
   always @(posedge clk) begin
      cyc++;
      if (rst_n) begin
         if (in_valid && in_ready) begin
            e_push     = model(dividend, divisor);
            e_push.acc = cyc;
            exp_q.push_back(e_push);
         end
         if (out_valid && out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            seen_head = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check_output("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check_output("quotient", 32'(quotient), 32'(exp_q[0].q));
            check_output("remainder", 32'(remainder), 32'(exp_q[0].r));
            check_output("div_by_zero", 32'(div_by_zero), 32'(exp_q[0].z));
            if (!seen_head) begin
               check_output("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
               seen_head = 1;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n        = 0;
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check_output("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) check_output("out_valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic run_literal(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
      apply_stimulus(a, b);
      wait_valid();
      check_output({name, "_q"}, 32'(quotient), 32'(eq));
      check_output({name, "_r"}, 32'(remainder), 32'(er));
      check_output({name, "_z"}, 32'(div_by_zero), 32'(ez));
      @(posedge clk);
      #1;
   endtask

   initial begin
      exp_t m;
      int   n;
      logic [W-1:0] a;
      logic [W-1:0] b;

      // Reset state
      #12;
      check_output("rst_in_ready", 32'(in_ready), 32'd1);
      check_output("rst_out_valid", 32'(out_valid), 32'd0);
      check_output("rst_quotient", 32'(quotient), 32'd0);
      check_output("rst_remainder", 32'(remainder), 32'd0);
      check_output("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single restoring step: 5*2+1=11 -> 11-7=4, bit 1; 2*2+0=4 < 7 -> 4, bit 0
      st_rem_in = 17'd5; st_div = 16'd7; st_bit = 1'b1;
      #1;
      check_output("step_a_rem", 32'(st_rem_out), 32'd4);
      check_output("step_a_bit", 32'(st_q), 32'd1);
      st_rem_in = 17'd2; st_bit = 1'b0;
      #1;
      check_output("step_b_rem", 32'(st_rem_out), 32'd4);
      check_output("step_b_bit", 32'(st_q), 32'd0);

      // Pin the model itself with hand-computed values
      m = model(16'd100, 16'd7);
      check_output("model_100_7_q", 32'(m.q), 32'd14);
      check_output("model_100_7_r", 32'(m.r), 32'd2);
      m = model(16'd55, 16'd0);
      check_output("model_55_0_q", 32'(m.q), 32'hFFFF);
      check_output("model_55_0_lat", 32'(m.lat), 32'd1);

      out_ready = 1'b1;
      run_literal("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
      run_literal("d55_0", 16'd55, 16'd0, 16'hFFFF, 16'd55, 1'b1);
      run_literal("d65535_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
`ifdef SEQ_DIV_SIGNED_EN
      run_literal("s_m7_2", 16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0);
      run_literal("s_7_m2", 16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0);
      run_literal("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0);
`else
      run_literal("d3_65535", 16'd3, 16'hFFFF, 16'd0, 16'd3, 1'b0);
`endif

      // Back-pressure: result must hold and no new op may slip in
      out_ready = 1'b0;
      apply_stimulus(16'd1000, 16'd10);
      wait_valid();
      in_valid = 1'b1;
      dividend = 16'd77;
      divisor  = 16'd5;
      for (int i = 0; i < 5; i++) begin
         check_output("bp_hold_q", 32'(quotient), 32'd100);
         check_output("bp_hold_r", 32'(remainder), 32'd0);
         check_output("bp_hold_valid", 32'(out_valid), 32'd1);
         check_output("bp_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check_output("bp_no_same_cycle_accept", 32'(in_ready), 32'd0);
      run_literal("bp_second", 16'd77, 16'd5, 16'd15, 16'd2, 1'b0);

      // Reset in the middle of an operation discards it
      apply_stimulus(16'hBEEF, 16'd3);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("midrst_in_ready", 32'(in_ready), 32'd1);
      check_output("midrst_out_valid", 32'(out_valid), 32'd0);
      check_output("midrst_quotient", 32'(quotient), 32'd0);
      exp_q.delete();
      seen_head = 0;
      #2 rst_n = 1'b1;
      repeat (25) @(negedge clk);
      @(posedge clk);
      #1;
      run_literal("after_rst_9_4", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0);

      // Random operands with random consumer back-pressure
      rand_ready = 1;
      for (int i = 0; i < 40; i++) begin
         n = int'($urandom_range(0, 9));
         a = W'($urandom);
         if (n == 0)      b = '0;
         else if (n <= 3) b = W'($urandom_range(1, 15));
         else if (n == 4) begin a = 16'h8000; b = 16'hFFFF; end
         else             b = W'($urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         apply_stimulus(a, b);
      end
      rand_ready = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check_output("drain_all", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
